// File: rtl/lpc_host_if.sv
// Request/response handshake between a local requester and the LPC host engine.
interface lpc_host_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [15:0] req_addr_i;
    logic [7:0]  req_data_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic [1:0]  rsp_status_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o
    );
endinterface

// File: rtl/lpc_host.sv
// LPC host engine: issues one I/O read or write cycle per request on LAD/LFRAME#,
// handles SYNC waits, SYNC errors and no-response / long-wait aborts.
module lpc_host #(
    parameter int unsigned LONG_WAIT_MAX = 1023,
    parameter int unsigned NORESP_MAX    = 3
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    output logic        lframe_o,
    inout  wire  [3:0]  lad_bus,
    lpc_host_if.slave   req_if,
    output logic [4:0]  current_state_o
);
    typedef enum logic [4:0] {
        S_IDLE, S_START, S_CYCTYPE, S_ADDR1, S_ADDR2, S_ADDR3, S_ADDR4,
        S_DATA_WR1, S_DATA_WR2, S_TAR1, S_TAR2, S_SYNC, S_DATA_RD1,
        S_DATA_RD2, S_FTAR1, S_FTAR2, S_ABORT
    } state_t;

    localparam int unsigned WCW = $clog2(LONG_WAIT_MAX + 2);
    localparam int unsigned NCW = $clog2(NORESP_MAX + 1);

    state_t           state, state_nxt;
    logic             wr_q;
    logic [15:0]      addr_q;
    logic [7:0]       wdata_q, rdata_q;
    logic [1:0]       status_q;
    logic [WCW-1:0]   wait_cnt, wait_inc;
    logic [NCW-1:0]   noresp_cnt, noresp_inc;
    logic [1:0]       abort_cnt;
    logic             lad_oe;
    logic [3:0]       lad_out, lad_in;
    logic             sync_done, sync_wait;

    assign lad_bus         = lad_oe ? lad_out : 4'bzzzz;
    assign lad_in          = lad_bus;
    assign current_state_o = state;
    assign req_if.req_ready_o = (state == S_IDLE);

    assign wait_inc   = wait_cnt + 1'b1;
    assign noresp_inc = noresp_cnt + 1'b1;
    assign sync_done  = (lad_in == 4'h0) || (lad_in == 4'hA);
    assign sync_wait  = (lad_in == 4'h5) || (lad_in == 4'h6);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        lframe_o  = 1'b1;
        lad_oe    = 1'b0;
        lad_out   = '0;
        case (state)
            S_IDLE:     if (req_if.req_valid_i) state_nxt = S_START;
            S_START: begin
                lframe_o  = 1'b0;
                lad_oe    = 1'b1;
                state_nxt = S_CYCTYPE;
            end
            S_CYCTYPE: begin
                lad_oe    = 1'b1;
                lad_out   = wr_q ? 4'h2 : 4'h0;
                state_nxt = S_ADDR1;
            end
            S_ADDR1: begin lad_oe = 1'b1; lad_out = addr_q[15:12]; state_nxt = S_ADDR2; end
            S_ADDR2: begin lad_oe = 1'b1; lad_out = addr_q[11:8];  state_nxt = S_ADDR3; end
            S_ADDR3: begin lad_oe = 1'b1; lad_out = addr_q[7:4];   state_nxt = S_ADDR4; end
            S_ADDR4: begin
                lad_oe    = 1'b1;
                lad_out   = addr_q[3:0];
                state_nxt = wr_q ? S_DATA_WR1 : S_TAR1;
            end
            S_DATA_WR1: begin lad_oe = 1'b1; lad_out = wdata_q[3:0]; state_nxt = S_DATA_WR2; end
            S_DATA_WR2: begin lad_oe = 1'b1; lad_out = wdata_q[7:4]; state_nxt = S_TAR1; end
            S_TAR1:     begin lad_oe = 1'b1; lad_out = 4'hF; state_nxt = S_TAR2; end
            S_TAR2:     state_nxt = S_SYNC;
            S_SYNC: begin
                // An error SYNC still completes the data phase; only the status differs.
                if (sync_done)
                    state_nxt = wr_q ? S_FTAR1 : S_DATA_RD1;
                else if (sync_wait) begin
                    if (wait_inc > WCW'(LONG_WAIT_MAX)) state_nxt = S_ABORT;
                end else if (noresp_inc >= NCW'(NORESP_MAX))
                    state_nxt = S_ABORT;
            end
            S_DATA_RD1: state_nxt = S_DATA_RD2;
            S_DATA_RD2: state_nxt = S_FTAR1;
            S_FTAR1:    state_nxt = S_FTAR2;
            S_FTAR2:    state_nxt = S_IDLE;
            S_ABORT: begin
                lframe_o = 1'b0;
                lad_oe   = 1'b1;
                lad_out  = 4'hF;
                if (abort_cnt == 2'd3) state_nxt = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_q                <= 1'b0;
            addr_q              <= '0;
            wdata_q             <= '0;
            rdata_q             <= '0;
            status_q            <= '0;
            wait_cnt            <= '0;
            noresp_cnt          <= '0;
            abort_cnt           <= '0;
            req_if.rsp_valid_o  <= 1'b0;
            req_if.rsp_data_o   <= '0;
            req_if.rsp_status_o <= '0;
        end else begin
            req_if.rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: if (req_if.req_valid_i) begin
                    wr_q    <= req_if.req_write_i;
                    addr_q  <= req_if.req_addr_i;
                    wdata_q <= req_if.req_data_i;
                end
                S_TAR2: begin
                    wait_cnt   <= '0;
                    noresp_cnt <= '0;
                    abort_cnt  <= '0;
                    status_q   <= 2'b00;
                end
                S_SYNC: begin
                    if (sync_done)
                        status_q <= (lad_in == 4'hA) ? 2'b01 : 2'b00;
                    else if (sync_wait) begin
                        wait_cnt   <= wait_inc;
                        noresp_cnt <= '0;
                    end else
                        noresp_cnt <= noresp_inc;
                end
                S_DATA_RD1: rdata_q[3:0] <= lad_in;
                S_DATA_RD2: rdata_q[7:4] <= lad_in;
                S_FTAR2: begin
                    req_if.rsp_valid_o  <= 1'b1;
                    req_if.rsp_status_o <= status_q;
                    if (!wr_q) req_if.rsp_data_o <= rdata_q;
                end
                S_ABORT: begin
                    abort_cnt <= abort_cnt + 1'b1;
                    if (abort_cnt == 2'd3) begin
                        req_if.rsp_valid_o  <= 1'b1;
                        req_if.rsp_status_o <= 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: scripted peripheral responses, scoreboard of expected completions.
module tb_lpc_host;
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    wire  [3:0] lad_bus;
    logic       lframe;
    logic [4:0] cur_state;
    logic       per_oe;
    logic [3:0] per_lad;
    lpc_host_if u_if ();

    lpc_host #(.LONG_WAIT_MAX(1023), .NORESP_MAX(3)) u_dut (
        .clk_i(clk), .nrst_i(nrst), .lframe_o(lframe), .lad_bus(lad_bus),
        .req_if(u_if.slave), .current_state_o(cur_state)
    );
    // Peripheral drives its scripted nibble; otherwise the bus floats high.
    assign lad_bus = u_dut.lad_oe ? 4'bzzzz : (per_oe ? per_lad : 4'hF);

    // Second host with a short wait limit; its peripheral answers 0x5 forever.
    wire  [3:0] lad_lw;
    logic       lframe_lw;
    logic [4:0] state_lw;
    lpc_host_if u_if_lw ();

    lpc_host #(.LONG_WAIT_MAX(4), .NORESP_MAX(3)) u_lw (
        .clk_i(clk), .nrst_i(nrst), .lframe_o(lframe_lw), .lad_bus(lad_lw),
        .req_if(u_if_lw.slave), .current_state_o(state_lw)
    );
    assign lad_lw = u_lw.lad_oe ? 4'bzzzz : 4'h5;

    typedef struct {
        logic [1:0]  status;
        logic [7:0]  data;
        int unsigned latency;
    } exp_t;

    exp_t        sb[$];
    logic [5:0]  trace[$];
    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    logic [7:0]  last_rd = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        #1;
        trace.push_back({lframe, u_dut.lad_oe, lad_bus});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic w, input logic [15:0] a, input logic [7:0] d);
        int unsigned guard = 0;
        @(negedge clk);
        u_if.req_valid_i = 1'b1;
        u_if.req_write_i = w;
        u_if.req_addr_i  = a;
        u_if.req_data_i  = d;
        while (!u_if.req_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", u_if.req_ready_o, 1);
        @(posedge clk);
        #1;
        u_if.req_valid_i = 1'b0;
        acc_cyc = cyc;
        trace.delete();
    endtask

    task automatic wait_rsp(input string tag);
        int unsigned n = 0;
        exp_t e;
        while (!u_if.rsp_valid_o && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        chk({tag, "_valid"},   u_if.rsp_valid_o, 1);
        chk({tag, "_status"},  u_if.rsp_status_o, e.status);
        chk({tag, "_data"},    u_if.rsp_data_o, e.data);
        chk({tag, "_latency"}, cyc - acc_cyc, e.latency);
        chk({tag, "_ready"},   u_if.req_ready_o, 1);
        @(negedge clk);
        #1;
        chk({tag, "_pulse"},   u_if.rsp_valid_o, 0);
    endtask

    // resp holds the peripheral nibbles from the first SYNC clock, lowest nibble first.
    task automatic xfer(input string tag, input logic w, input logic [15:0] a, input logic [7:0] d,
                        input int unsigned nresp, input logic [63:0] resp,
                        input logic [1:0] exp_st, input logic [7:0] exp_data, input int unsigned exp_lat);
        exp_t e;
        int unsigned ks;
        e.status = exp_st;
        e.data = exp_data;
        e.latency = exp_lat;
        sb.push_back(e);
        accept(w, a, d);
        ks = w ? 10 : 8;
        for (int unsigned k = 0; k <= ks + nresp; k++) begin
            @(negedge clk);
            if (k >= ks && k < ks + nresp) begin
                per_oe  = 1'b1;
                per_lad = resp[4*(k-ks) +: 4];
            end else
                per_oe = 1'b0;
        end
        wait_rsp(tag);
    endtask

    logic [4:0] wr_tab [13] = '{5'h10, 5'h12, 5'h10, 5'h10, 5'h18, 5'h10, 5'h1A,
                                5'h15, 5'h1F, 5'h0F, 5'h00, 5'h0F, 5'h0F};
    logic [15:0] rd_addr = 16'h03F8;

    initial begin
        int unsigned lf_low;
        int unsigned seen;
        int unsigned n;
        nrst = 1'b0;
        per_oe = 1'b0;
        per_lad = 4'h0;
        u_if.req_valid_i = 1'b0; u_if.req_write_i = 1'b0; u_if.req_addr_i = '0; u_if.req_data_i = '0;
        u_if_lw.req_valid_i = 1'b0; u_if_lw.req_write_i = 1'b0; u_if_lw.req_addr_i = '0; u_if_lw.req_data_i = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_lframe", lframe, 1);
        chk("rst_lad_oe", u_dut.lad_oe, 0);
        chk("rst_rsp_valid", u_if.rsp_valid_o, 0);
        chk("rst_rsp_data", u_if.rsp_data_o, 8'h00);
        chk("rst_rsp_status", u_if.rsp_status_o, 2'b00);
        chk("rst_state", cur_state, 5'd0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("rst_ready", u_if.req_ready_o, 1);

        // Zero-wait write 0x5A to 0x0080
        xfer("wr0", 1'b1, 16'h0080, 8'h5A, 1, 64'h0, 2'b00, last_rd, 13);
        for (int unsigned k = 0; k < 13; k++)
            chk($sformatf("wr0_lad%0d", k), trace[k][4:0], wr_tab[k]);

        // Zero-wait read of 0x03F8 returning 0xC7
        xfer("rd0", 1'b0, rd_addr, 8'h00, 3, 64'hC70, 2'b00, 8'hC7, 13);
        last_rd = 8'hC7;
        lf_low = 0;
        for (int unsigned k = 0; k < 14; k++) if (!trace[k][5]) lf_low++;
        chk("rd0_lframe_low", lf_low, 1);
        for (int unsigned i = 0; i < 4; i++)
            chk($sformatf("rd0_addr%0d", i), trace[2+i][4:0], {1'b1, rd_addr[15-4*i -: 4]});

        // Five wait SYNCs then data 0x11
        xfer("rdw", 1'b0, 16'h0060, 8'h00, 8, 64'h11066666, 2'b00, 8'h11, 18);
        last_rd = 8'h11;

        // Nobody answers: three SYNC clocks then a four-clock abort
        xfer("nrs", 1'b0, 16'h0064, 8'h00, 0, 64'h0, 2'b10, last_rd, 15);
        for (int unsigned k = 8; k < 11; k++)
            chk($sformatf("nrs_sync%0d", k), trace[k][5:4], 2'b10);
        for (int unsigned k = 11; k < 15; k++)
            chk($sformatf("nrs_abort%0d", k), trace[k], 6'b01_1111);
        chk("nrs_idle_lframe", trace[15][5], 1);

        // Error SYNC on a write
        xfer("wre", 1'b1, 16'h0300, 8'h3C, 1, 64'hA, 2'b01, last_rd, 13);

        // Continuous short wait exceeds a limit of 4
        @(negedge clk);
        u_if_lw.req_valid_i = 1'b1;
        u_if_lw.req_addr_i  = 16'h0070;
        @(posedge clk);
        #1;
        u_if_lw.req_valid_i = 1'b0;
        acc_cyc = cyc;
        n = 0;
        while (!u_if_lw.rsp_valid_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("lw_valid", u_if_lw.rsp_valid_o, 1);
        chk("lw_status", u_if_lw.rsp_status_o, 2'b10);
        chk("lw_data", u_if_lw.rsp_data_o, 8'h00);
        chk("lw_latency", cyc - acc_cyc, 17);

        // Reset while ADDR3 is on the bus; the interrupted request gets no response
        accept(1'b1, 16'h1234, 8'hA5);
        repeat (5) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("mrst_lframe", lframe, 1);
        chk("mrst_lad_oe", u_dut.lad_oe, 0);
        chk("mrst_state", cur_state, 5'd0);
        chk("mrst_rsp_valid", u_if.rsp_valid_o, 0);
        chk("mrst_rsp_data", u_if.rsp_data_o, 8'h00);
        last_rd = 8'h00;
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            #1;
            if (u_if.rsp_valid_o) seen++;
        end
        chk("mrst_no_rsp", seen, 0);

        // Normal read after reset
        xfer("rdr", 1'b0, 16'h0201, 8'h00, 3, 64'h5C0, 2'b00, 8'h5C, 13);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1);
    end
endmodule
